// File: rtl/instr_mem_responder.sv
// Fetch-side instruction memory: one outstanding request, fixed wait states, preloadable word array.
// Optional alignment/range checking is enabled by defining IMEM_ADDR_CHECK_EN.
module instr_mem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_addr,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_instr,
    output logic [31:0]                rsp_pc,
    output logic                       rsp_err,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [31:0]                wr_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   word_idx_c;
    logic            addr_err_c;
    logic [31:0]     rd_word_c;

    assign word_idx_c = req_addr[AW+1:2];
    assign rd_word_c  = mem[word_idx_c];

`ifdef IMEM_ADDR_CHECK_EN
    // Misaligned PC or any address at/above DEPTH*4 is answered with a NOP and an error flag.
    assign addr_err_c = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
    logic addr_unused;
    assign addr_unused = ^{req_addr[31:AW+2], req_addr[1:0], NOP_WORD};
    assign addr_err_c  = 1'b0;
`endif

    // Program store: not reset, so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Request/response sequencer with registered handshake and payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_pc    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        rsp_pc    <= req_addr;
                        rsp_err   <= addr_err_c;
                        rsp_instr <= addr_err_c ? NOP_WORD : rd_word_c;
                        cnt       <= CW'(WAIT_STATES);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
// Expectations follow IMEM_ADDR_CHECK_EN when it is defined for the build.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic        a_req_valid = 1'b0, a_rsp_ready = 1'b0;
    logic [31:0] a_req_addr = '0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_instr, a_rsp_pc;

    logic        b_req_valid = 1'b0, b_rsp_ready = 1'b0;
    logic [31:0] b_req_addr = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_instr, b_rsp_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH(64), .WAIT_STATES(2), .NOP_WORD(32'h0000_0013)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_instr(a_rsp_instr),
        .rsp_pc(a_rsp_pc), .rsp_err(a_rsp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    instr_mem_responder #(.DEPTH(64), .WAIT_STATES(0), .NOP_WORD(32'h0000_0013)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr),
        .rsp_pc(b_rsp_pc), .rsp_err(b_rsp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [5:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Issue one request to dut_a, optionally with a write on the acceptance edge,
    // and check that rsp_valid rises exactly three edges after acceptance.
    task automatic req_a(input logic [31:0] addr, input logic do_wr,
                         input logic [5:0] wa, input logic [31:0] wd);
        int n = 0;
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        while (!a_req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("a_ready_wait", 32'(a_req_ready), 32'd1);
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        end
        tick();
        wr_en = 1'b0;
        a_req_valid = 1'b0;
        chk("a_ready_after_accept", 32'(a_req_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("a_valid_early", 32'(a_rsp_valid), 32'd0);
        end
        tick();
        chk("a_valid_latency", 32'(a_rsp_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_instr;
        logic        exp_err;
        logic [31:0] b_addrs [3];
        logic [31:0] b_words [3];

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", 32'(a_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_instr", a_rsp_instr, 32'd0);
        chk("rst_rsp_pc", a_rsp_pc, 32'd0);
        chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        reset = 1'b1;
        tick();
        chk("ready_after_release", 32'(a_req_ready), 32'd1);

        for (int i = 0; i < 4; i++) write_word(6'(i), 32'hA0 + 32'(i));

        // Basic fetch with consumer ready
        a_rsp_ready = 1'b1;
        req_a(32'h4, 1'b0, 6'd0, 32'd0);
        chk("t1_instr", a_rsp_instr, 32'hA1);
        chk("t1_pc", a_rsp_pc, 32'h4);
        chk("t1_err", 32'(a_rsp_err), 32'd0);
        tick();
        chk("t1_valid_done", 32'(a_rsp_valid), 32'd0);
        chk("t1_ready_back", 32'(a_req_ready), 32'd1);

        // Back-pressure: response held stable for five cycles
        a_rsp_ready = 1'b0;
        req_a(32'h8, 1'b0, 6'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 32'(a_rsp_valid), 32'd1);
            chk("t2_hold_instr", a_rsp_instr, 32'hA2);
            chk("t2_hold_pc", a_rsp_pc, 32'h8);
            chk("t2_hold_ready", 32'(a_req_ready), 32'd0);
        end
        a_rsp_ready = 1'b1;
        tick();
        chk("t2_ready_after_hs", 32'(a_req_ready), 32'd1);
        chk("t2_valid_after_hs", 32'(a_rsp_valid), 32'd0);

        // Misaligned and out-of-range addresses
`ifdef IMEM_ADDR_CHECK_EN
        exp_instr = 32'h0000_0013; exp_err = 1'b1;
`else
        exp_instr = 32'hA1; exp_err = 1'b0;
`endif
        req_a(32'h6, 1'b0, 6'd0, 32'd0);
        chk("t3_mis_instr", a_rsp_instr, exp_instr);
        chk("t3_mis_err", 32'(a_rsp_err), 32'(exp_err));
        tick();
`ifdef IMEM_ADDR_CHECK_EN
        exp_instr = 32'h0000_0013; exp_err = 1'b1;
`else
        exp_instr = 32'hA0; exp_err = 1'b0;
`endif
        req_a(32'h100, 1'b0, 6'd0, 32'd0);
        chk("t3_oor_instr", a_rsp_instr, exp_instr);
        chk("t3_oor_err", 32'(a_rsp_err), 32'(exp_err));
        chk("t3_oor_pc", a_rsp_pc, 32'h100);
        tick();

        // Write on the acceptance edge returns old data; next fetch sees new data
        req_a(32'hC, 1'b1, 6'd3, 32'hBB);
        chk("t4_same_edge", a_rsp_instr, 32'hA3);
        tick();
        req_a(32'hC, 1'b0, 6'd0, 32'd0);
        chk("t4_after_write", a_rsp_instr, 32'hBB);
        tick();

        // Reset during WAIT drops the pending request
        a_req_valid = 1'b1;
        a_req_addr  = 32'h8;
        tick();
        a_req_valid = 1'b0;
        tick();
        chk("t5_pc_before_rst", a_rsp_pc, 32'h8);
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(a_rsp_valid), 32'd0);
        chk("t5_rst_ready", 32'(a_req_ready), 32'd0);
        chk("t5_rst_pc", a_rsp_pc, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_dropped", 32'(a_rsp_valid), 32'd0);
        end
        req_a(32'h0, 1'b0, 6'd0, 32'd0);
        chk("t5_retained", a_rsp_instr, 32'hA0);
        tick();

        // Zero-wait instance with requests held continuously
        b_addrs[0] = 32'h0; b_addrs[1] = 32'h4; b_addrs[2] = 32'h8;
        b_words[0] = 32'hA0; b_words[1] = 32'hA1; b_words[2] = 32'hA2;
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        b_req_addr  = b_addrs[0];
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            while (!b_req_ready && n < 20) begin
                tick();
                n++;
            end
            chk("b_ready_wait", 32'(b_req_ready), 32'd1);
            tick();
            b_req_addr = (i < 2) ? b_addrs[i+1] : 32'h0;
            chk("b_valid_low", 32'(b_rsp_valid), 32'd0);
            tick();
            chk("b_valid_high", 32'(b_rsp_valid), 32'd1);
            chk("b_instr", b_rsp_instr, b_words[i]);
            chk("b_pc", b_rsp_pc, b_addrs[i]);
            tick();
            chk("b_consumed", 32'(b_rsp_valid), 32'd0);
            chk("b_ready_back", 32'(b_req_ready), 32'd1);
        end
        b_req_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
